// File: rtl/switch_cfg_tx.sv
// Configuration-packet transmitter: serializes one LUT/dateline write into a
// head+body flit pair, then waits for a tagged ack with timeout and bounded retry.
module switch_cfg_tx #(
  parameter int NUM_OUTPORTS = 4,
  parameter int TABLE_SIZE   = 32,
  parameter int TIMEOUT      = 64,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_kind,
  input  logic [4:0]  req_dest,
  input  logic [7:0]  req_index,
  input  logic [15:0] req_data,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [31:0] flit_data,
  output logic        flit_last,
  input  logic        ack_valid,
  input  logic [7:0]  ack_seq,
  input  logic        ack_ok,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [15:0] DL_MASK  = 16'((32'd1 << NUM_OUTPORTS) - 32'd1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_WAIT} state_t;

  state_t          state_q;
  logic            kind_q;
  logic [4:0]      dest_q;
  logic [7:0]      idx_q;
  logic [15:0]     data_q;
  logic [7:0]      seq_q;
  logic [7:0]      seq_ctr_q;
  logic [RT_W-1:0] retry_q;
  logic [TO_W-1:0] to_q;
  logic            flit_valid_q;
  logic            flit_last_q;
  logic [31:0]     flit_data_q;
  logic            done_q;
  logic            err_q;

  function automatic logic [31:0] head_flit(input logic [4:0] d, input logic k,
                                            input logic [7:0] i, input logic [7:0] s);
    return {2'b01, d, k, i, s, 8'h00};
  endfunction

  function automatic logic [31:0] body_flit(input logic [15:0] dat);
    return {2'b10, 14'b0, dat};
  endfunction

  // Request fields normalized at capture so retransmits reuse them verbatim.
  logic [7:0]  idx_d;
  logic [15:0] data_d;
  logic        idx_bad;
  logic        ack_match;

  always_comb begin
    idx_d     = req_kind ? 8'h00 : req_index;
    data_d    = req_kind ? (req_data & DL_MASK) : req_data;
    idx_bad   = !req_kind && ({24'd0, req_index} >= 32'(TABLE_SIZE));
    ack_match = ack_valid && (ack_seq == seq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kind_q       <= 1'b0;
      dest_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      seq_q        <= '0;
      seq_ctr_q    <= '0;
      retry_q      <= '0;
      to_q         <= '0;
      flit_valid_q <= 1'b0;
      flit_last_q  <= 1'b0;
      flit_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            kind_q <= req_kind;
            dest_q <= req_dest;
            idx_q  <= idx_d;
            data_q <= data_d;
            if (idx_bad) begin
              err_q <= 1'b1;
            end else begin
              seq_q        <= seq_ctr_q;
              seq_ctr_q    <= seq_ctr_q + 8'd1;
              retry_q      <= '0;
              state_q      <= S_HEAD;
              flit_valid_q <= 1'b1;
              flit_last_q  <= 1'b0;
              flit_data_q  <= head_flit(req_dest, req_kind, idx_d, seq_ctr_q);
            end
          end
        end
        S_HEAD: begin
          if (flit_ready) begin
            state_q     <= S_BODY;
            flit_last_q <= 1'b1;
            flit_data_q <= body_flit(data_q);
          end
        end
        S_BODY: begin
          if (flit_ready) begin
            state_q      <= S_WAIT;
            flit_valid_q <= 1'b0;
            flit_last_q  <= 1'b0;
            flit_data_q  <= '0;
            to_q         <= '0;
          end
        end
        S_WAIT: begin
          // A matching ack wins over a simultaneous timeout expiry.
          if (ack_match && ack_ok) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (ack_match || to_q == TO_LAST) begin
            if (retry_q < RT_MAX) begin
              retry_q      <= retry_q + 1'b1;
              state_q      <= S_HEAD;
              flit_valid_q <= 1'b1;
              flit_last_q  <= 1'b0;
              flit_data_q  <= head_flit(dest_q, kind_q, idx_q, seq_q);
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign flit_valid = flit_valid_q;
  assign flit_last  = flit_last_q;
  assign flit_data  = flit_data_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_switch_cfg_tx.sv
// Directed bench for switch_cfg_tx: basic write, backpressure, timeout/retry,
// nack recovery, dateline masking, bad index, reset abort and seq wrap.
module tb_switch_cfg_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_kind;
  logic [4:0]  req_dest;
  logic [7:0]  req_index;
  logic [15:0] req_data;
  logic        flit_valid, flit_ready, flit_last;
  logic [31:0] flit_data;
  logic        ack_valid, ack_ok;
  logic [7:0]  ack_seq;
  logic        done, err, busy;

  int errors = 0;
  int checks = 0;

  switch_cfg_tx #(.NUM_OUTPORTS(4), .TABLE_SIZE(32), .TIMEOUT(64), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_dest(req_dest), .req_index(req_index), .req_data(req_data),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
    .flit_last(flit_last),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .ack_ok(ack_ok),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic k, input logic [4:0] d, input logic [7:0] i,
                          input logic [15:0] dat);
    req_kind = k; req_dest = d; req_index = i; req_data = dat;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [7:0] s, input logic ok);
    ack_valid = 1'b1; ack_seq = s; ack_ok = ok;
    step();
    ack_valid = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; req_valid = 0; req_kind = 0; req_dest = 0; req_index = 0; req_data = 0;
    flit_ready = 1'b1; ack_valid = 0; ack_seq = 0; ack_ok = 0;
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_flit_last", 32'(flit_last), 32'd0);
    chk("rst_flit_data", flit_data, 32'h0);
    chk("rst_done_err_busy", {29'd0, done, err, busy}, 32'd0);
    rst = 1'b0;
    step();

    // Basic LUT write, seq 0
    send_req(1'b0, 5'd3, 8'd5, 16'h00A2);
    chk("basic_head_valid", 32'(flit_valid), 32'd1);
    chk("basic_head", flit_data, 32'h46050000);
    chk("basic_head_last", 32'(flit_last), 32'd0);
    chk("basic_busy", {30'd0, busy, req_ready}, 32'b10);
    step();
    chk("basic_body", flit_data, 32'h800000A2);
    chk("basic_body_last", 32'(flit_last), 32'd1);
    step();
    chk("basic_wait_novalid", 32'(flit_valid), 32'd0);
    ack(8'd0, 1'b1);
    chk("basic_done", {30'd0, done, err}, 32'b10);
    chk("basic_req_ready", 32'(req_ready), 32'd1);
    step();
    chk("basic_done_pulse", 32'(done), 32'd0);

    // Backpressure on head, seq 1
    flit_ready = 1'b0;
    send_req(1'b0, 5'd1, 8'd2, 16'h1234);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (flit_valid !== 1'b1 || flit_data !== 32'h42020100 || flit_last !== 1'b0) bad++;
      step();
    end
    chk("bp_head_stable", 32'(bad), 32'd0);
    chk("bp_still_head", flit_data, 32'h42020100);
    flit_ready = 1'b1;
    step();
    chk("bp_body", flit_data, 32'h80001234);
    step();
    ack(8'd1, 1'b1);
    chk("bp_done", 32'(done), 32'd1);

    // Timeout with full retries, seq 2
    send_req(1'b0, 5'd2, 8'd3, 16'h0055);
    for (int rep = 0; rep < 4; rep++) begin
      chk("to_head", {31'd0, flit_valid}, 32'd1);
      chk("to_head_word", flit_data, 32'h44030200);
      step();
      chk("to_body_word", flit_data, 32'h80000055);
      step();
      bad = 0;
      for (int k = 0; k < 63; k++) begin
        step();
        if (flit_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad++;
      end
      chk("to_quiet_window", 32'(bad), 32'd0);
      step();
    end
    chk("to_err", {30'd0, done, err}, 32'b01);
    chk("to_idle", {30'd0, flit_valid, req_ready}, 32'b01);

    // Non-matching ack, nack, then success, seq 3
    send_req(1'b0, 5'd4, 8'd9, 16'hBEEF);
    chk("nack_head", flit_data, 32'h48090300);
    step();
    chk("nack_body", flit_data, 32'h8000BEEF);
    step();
    ack(8'd7, 1'b1);
    chk("nack_ignore_other_seq", {29'd0, flit_valid, done, err}, 32'd0);
    ack(8'd3, 1'b0);
    chk("nack_resend_head", flit_data, 32'h48090300);
    chk("nack_resend_valid", {29'd0, flit_valid, done, err}, 32'b100);
    step(); step();
    ack(8'd3, 1'b1);
    chk("nack_done", {30'd0, done, err}, 32'b10);

    // Dateline write, seq 4
    send_req(1'b1, 5'd5, 8'h77, 16'hFFFF);
    chk("dl_head", flit_data, 32'h4B000400);
    step();
    chk("dl_body", flit_data, 32'h8000000F);
    step();
    ack(8'd4, 1'b1);
    chk("dl_done", 32'(done), 32'd1);

    // Out-of-range index: err, no flits, seq not consumed
    send_req(1'b0, 5'd6, 8'd40, 16'h1111);
    chk("badidx_err", {28'd0, err, done, flit_valid, busy}, 32'b1000);
    send_req(1'b0, 5'd6, 8'd1, 16'h2222);
    chk("badidx_seq_kept", flit_data, 32'h4C010500);
    step(); step();
    ack(8'd5, 1'b1);
    chk("badidx_next_done", 32'(done), 32'd1);

    // Reset during body
    send_req(1'b0, 5'd7, 8'd2, 16'h3333);
    step();
    chk("rst_mid_in_body", 32'(flit_last), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", {29'd0, flit_valid, done, err}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_ready", {30'd0, req_ready, busy}, 32'b10);

    // 256 requests walk seq 0..255, then wrap back to 0
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      send_req(1'b0, 5'd0, 8'd0, 16'h0000);
      if (flit_data !== {16'h4000, 8'(i), 8'h00}) bad++;
      step(); step();
      ack(8'(i), 1'b1);
      if (done !== 1'b1) bad++;
    end
    chk("wrap_walk", 32'(bad), 32'd0);
    send_req(1'b0, 5'd0, 8'd0, 16'h0000);
    chk("wrap_seq0", flit_data, 32'h40000000);
    step(); step();
    ack(8'd0, 1'b1);
    chk("wrap_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
